pipe_wb: RTL and testbench

PIPE_WB -- requirements
Module: pipe_wb

---
 rtl/pipe_wb_pkg.sv | 51 +++++
 rtl/pipe_wb_if.sv | 39 +++
 rtl/wb_load_ext.sv | 31 +++
 rtl/pipe_wb.sv | 80 ++++++++
 tb/tb_pipe_wb.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/pipe_wb_pkg.sv
// rtl/pipe_wb_pkg.sv - shared CPU encodings for load size and write-back data select
// Decode helpers keep the size and wd-select priority in one place for control and WB.
package pipe_wb_pkg;

  typedef enum logic [1:0] {
    LD_WORD = 2'd0,
    LD_HALF = 2'd1,
    LD_BYTE = 2'd2
  } ld_size_e;

  typedef enum logic [1:0] {
    WD_HI  = 2'd0,
    WD_LO  = 2'd1,
    WD_MEM = 2'd2,
    WD_ALU = 2'd3
  } wd_sel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  wa;
    logic        wrf;
    logic        wdc;
    logic        overflow;
    logic        w;
    logic        h;
    logic        b;
    logic        z;
    logic        mthi;
    logic        mtlo;
    logic        mfhi;
    logic        mflo;
  } wb_reg_t;

  // Word wins over half over byte; no size bit set means a full-word load.
  function automatic ld_size_e ld_size(input logic w, input logic h, input logic b);
    if (w)      return LD_WORD;
    else if (h) return LD_HALF;
    else if (b) return LD_BYTE;
    else        return LD_WORD;
  endfunction

  function automatic wd_sel_e wd_sel(input logic mfhi, input logic mflo, input logic wdc);
    if (mfhi)      return WD_HI;
    else if (mflo) return WD_LO;
    else if (wdc)  return WD_MEM;
    else           return WD_ALU;
  endfunction

endpackage

// File: rtl/pipe_wb_if.sv
// rtl/pipe_wb_if.sv - MEM-to-WB bundle plus the write-back results
// Master is the MEM stage side; slave is the WB stage.
interface pipe_wb_if;
  logic        valid_m;
  logic        stall;
  logic        flush;
  logic [31:0] alu_m;
  logic [31:0] mem_m;
  logic [4:0]  wa_m;
  logic        wrf_m;
  logic        wdc_m;
  logic        overflow_m;
  logic        w_m;
  logic        h_m;
  logic        b_m;
  logic        z_m;
  logic        mthi_m;
  logic        mtlo_m;
  logic        mfhi_m;
  logic        mflo_m;
  logic [31:0] wd;
  logic        rf_wena;
  logic [4:0]  wa;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        valid_w;

  modport master (
    output valid_m, stall, flush, alu_m, mem_m, wa_m, wrf_m, wdc_m, overflow_m,
           w_m, h_m, b_m, z_m, mthi_m, mtlo_m, mfhi_m, mflo_m,
    input  wd, rf_wena, wa, hi, lo, valid_w
  );

  modport slave (
    input  valid_m, stall, flush, alu_m, mem_m, wa_m, wrf_m, wdc_m, overflow_m,
           w_m, h_m, b_m, z_m, mthi_m, mtlo_m, mfhi_m, mflo_m,
    output wd, rf_wena, wa, hi, lo, valid_w
  );
endinterface

// File: rtl/wb_load_ext.sv
// rtl/wb_load_ext.sv - little-endian byte/half/word extraction with sign or zero extension
module wb_load_ext
  import pipe_wb_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [31:0] mem_i,
  input  ld_size_e    size_i,
  input  logic        zext_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = mem_i[7:0];
      2'd1:    byte_sel = mem_i[15:8];
      2'd2:    byte_sel = mem_i[23:16];
      default: byte_sel = mem_i[31:24];
    endcase
    half_sel = addr_i[1] ? mem_i[31:16] : mem_i[15:0];

    case (size_i)
      LD_HALF: data_o = {{16{half_sel[15] & ~zext_i}}, half_sel};
      LD_BYTE: data_o = {{24{byte_sel[7] & ~zext_i}}, byte_sel};
      default: data_o = mem_i;
    endcase
  end

endmodule

// File: rtl/pipe_wb.sv
// rtl/pipe_wb.sv - write-back pipeline register, HI/LO state and write-back data mux
// HI/LO are written from the instruction sitting in WB, so a same-cycle mfhi/mflo sees the old value.
module pipe_wb
  import pipe_wb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  pipe_wb_if.slave  bus
);

  wb_reg_t     wb_q, wb_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] ld_data;
  logic        commit;

  always_comb begin
    wb_d = wb_q;
    if (bus.flush) begin
      wb_d = '0;
    end else if (!bus.stall) begin
      wb_d.valid    = bus.valid_m;
      wb_d.alu      = bus.alu_m;
      wb_d.mem      = bus.mem_m;
      wb_d.wa       = bus.wa_m;
      wb_d.wrf      = bus.wrf_m;
      wb_d.wdc      = bus.wdc_m;
      wb_d.overflow = bus.overflow_m;
      wb_d.w        = bus.w_m;
      wb_d.h        = bus.h_m;
      wb_d.b        = bus.b_m;
      wb_d.z        = bus.z_m;
      wb_d.mthi     = bus.mthi_m;
      wb_d.mtlo     = bus.mtlo_m;
      wb_d.mfhi     = bus.mfhi_m;
      wb_d.mflo     = bus.mflo_m;
    end
  end

  // A stalled valid instruction rewrites the same HI/LO value each cycle, which is harmless.
  assign commit = wb_q.valid & ~wb_q.overflow;
  assign hi_d   = (commit & wb_q.mthi) ? wb_q.alu : hi_q;
  assign lo_d   = (commit & wb_q.mtlo) ? wb_q.alu : lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      wb_q <= wb_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  wb_load_ext u_load_ext (
    .addr_i (wb_q.alu[1:0]),
    .mem_i  (wb_q.mem),
    .size_i (ld_size(wb_q.w, wb_q.h, wb_q.b)),
    .zext_i (wb_q.z),
    .data_o (ld_data)
  );

  always_comb begin
    case (wd_sel(wb_q.mfhi, wb_q.mflo, wb_q.wdc))
      WD_HI:   bus.wd = hi_q;
      WD_LO:   bus.wd = lo_q;
      WD_MEM:  bus.wd = ld_data;
      default: bus.wd = wb_q.alu;
    endcase
  end

  assign bus.rf_wena = wb_q.valid & wb_q.wrf & ~wb_q.overflow;
  assign bus.wa      = wb_q.wa;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.valid_w = wb_q.valid;

endmodule

// File: tb/tb_pipe_wb.sv
// tb/tb_pipe_wb.sv - scoreboard bench for pipe_wb with directed vectors
module tb_pipe_wb;

  localparam logic [10:0] C_WRF  = 11'h400;
  localparam logic [10:0] C_WDC  = 11'h200;
  localparam logic [10:0] C_OV   = 11'h100;
  localparam logic [10:0] C_W    = 11'h080;
  localparam logic [10:0] C_H    = 11'h040;
  localparam logic [10:0] C_B    = 11'h020;
  localparam logic [10:0] C_Z    = 11'h010;
  localparam logic [10:0] C_MTHI = 11'h008;
  localparam logic [10:0] C_MTLO = 11'h004;
  localparam logic [10:0] C_MFHI = 11'h002;
  localparam logic [10:0] C_MFLO = 11'h001;

  typedef struct {
    logic        v;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] hi;
    logic [31:0] lo;
    int          id;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;
  exp_t sb[$];

  pipe_wb_if bus ();

  pipe_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, req);
    end
  endtask

  // Monitor: outputs are purely registered, so the negedge sample is race-free.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("valid_w", e.id, {31'd0, bus.valid_w}, {31'd0, e.v});
        chk("rf_wena", e.id, {31'd0, bus.rf_wena}, {31'd0, e.we});
        chk("wa",      e.id, {27'd0, bus.wa},      {27'd0, e.wa});
        chk("wd",      e.id, bus.wd, e.wd);
        chk("hi",      e.id, bus.hi, e.hi);
        chk("lo",      e.id, bus.lo, e.lo);
      end
    end
  end

  task automatic step(input logic rs, input logic st, input logic fl, input logic v,
                      input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] wa,
                      input logic [10:0] ctl,
                      input logic e_v, input logic e_we, input logic [4:0] e_wa,
                      input logic [31:0] e_wd, input logic [31:0] e_hi, input logic [31:0] e_lo);
    exp_t e;
    rst            = rs;
    bus.stall      = st;
    bus.flush      = fl;
    bus.valid_m    = v;
    bus.alu_m      = alu;
    bus.mem_m      = mem;
    bus.wa_m       = wa;
    bus.wrf_m      = ctl[10];
    bus.wdc_m      = ctl[9];
    bus.overflow_m = ctl[8];
    bus.w_m        = ctl[7];
    bus.h_m        = ctl[6];
    bus.b_m        = ctl[5];
    bus.z_m        = ctl[4];
    bus.mthi_m     = ctl[3];
    bus.mtlo_m     = ctl[2];
    bus.mfhi_m     = ctl[1];
    bus.mflo_m     = ctl[0];
    @(posedge clk);
    step_id++;
    e.v = e_v; e.we = e_we; e.wa = e_wa; e.wd = e_wd; e.hi = e_hi; e.lo = e_lo; e.id = step_id;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    int budget;
    @(negedge clk);
    //    rs st fl v  alu           mem           wa     ctl                        ev we wa     wd            hi            lo
    step(1, 0, 0, 0, 32'h0,        32'h0,        5'd0,  11'h0,                     0, 0, 5'd0,  32'h0,        32'h0,        32'h0);
    step(1, 1, 1, 1, 32'h5,        32'h0,        5'd3,  C_WRF,                     0, 0, 5'd0,  32'h0,        32'h0,        32'h0);
    // loads: byte, half, word and default-size
    step(0, 0, 0, 1, 32'h2,        32'h80FF7F01, 5'd5,  C_WRF|C_WDC|C_B,           1, 1, 5'd5,  32'hFFFFFFFF, 32'h0,        32'h0);
    step(0, 0, 0, 1, 32'h2,        32'h80FF7F01, 5'd5,  C_WRF|C_WDC|C_B|C_Z,       1, 1, 5'd5,  32'h000000FF, 32'h0,        32'h0);
    step(0, 0, 0, 1, 32'h0,        32'h80FF7F01, 5'd6,  C_WRF|C_WDC|C_B,           1, 1, 5'd6,  32'h00000001, 32'h0,        32'h0);
    step(0, 0, 0, 1, 32'h1,        32'h80FF7F01, 5'd6,  C_WRF|C_WDC|C_B,           1, 1, 5'd6,  32'h0000007F, 32'h0,        32'h0);
    step(0, 0, 0, 1, 32'h3,        32'h80FF7F01, 5'd6,  C_WRF|C_WDC|C_B,           1, 1, 5'd6,  32'hFFFFFF80, 32'h0,        32'h0);
    step(0, 0, 0, 1, 32'h2,        32'h8001ABCD, 5'd7,  C_WRF|C_WDC|C_H,           1, 1, 5'd7,  32'hFFFF8001, 32'h0,        32'h0);
    step(0, 0, 0, 1, 32'h0,        32'h8001ABCD, 5'd7,  C_WRF|C_WDC|C_H|C_Z,       1, 1, 5'd7,  32'h0000ABCD, 32'h0,        32'h0);
    step(0, 0, 0, 1, 32'h0,        32'h8001ABCD, 5'd7,  C_WRF|C_WDC|C_H,           1, 1, 5'd7,  32'hFFFFABCD, 32'h0,        32'h0);
    step(0, 0, 0, 1, 32'h3,        32'h8001ABCD, 5'd8,  C_WRF|C_WDC|C_W|C_B|C_Z,   1, 1, 5'd8,  32'h8001ABCD, 32'h0,        32'h0);
    step(0, 0, 0, 1, 32'h1,        32'h8001ABCD, 5'd8,  C_WRF|C_WDC,               1, 1, 5'd8,  32'h8001ABCD, 32'h0,        32'h0);
    // ALU path, no-write and overflow
    step(0, 0, 0, 1, 32'h00001234, 32'h0,        5'd7,  C_WRF,                     1, 1, 5'd7,  32'h00001234, 32'h0,        32'h0);
    step(0, 0, 0, 1, 32'h0000AAAA, 32'h0,        5'd9,  11'h0,                     1, 0, 5'd9,  32'h0000AAAA, 32'h0,        32'h0);
    step(0, 0, 0, 1, 32'h0000BBBB, 32'h0,        5'd11, C_WRF|C_OV,                1, 0, 5'd11, 32'h0000BBBB, 32'h0,        32'h0);
    // HI/LO forwarding and suppression
    step(0, 0, 0, 1, 32'h12345678, 32'h0,        5'd0,  C_MTHI,                    1, 0, 5'd0,  32'h12345678, 32'h0,        32'h0);
    step(0, 0, 0, 1, 32'h0,        32'h0,        5'd4,  C_WRF|C_MFHI,              1, 1, 5'd4,  32'h12345678, 32'h12345678, 32'h0);
    step(0, 0, 0, 1, 32'h55,       32'h0,        5'd6,  C_WRF|C_MTLO|C_OV,         1, 0, 5'd6,  32'h55,       32'h12345678, 32'h0);
    step(0, 0, 0, 0, 32'h77,       32'h0,        5'd8,  C_WRF|C_MTLO,              0, 0, 5'd8,  32'h77,       32'h12345678, 32'h0);
    step(0, 0, 0, 1, 32'hCAFE0001, 32'h0,        5'd0,  C_MTLO,                    1, 0, 5'd0,  32'hCAFE0001, 32'h12345678, 32'h0);
    step(0, 0, 0, 1, 32'hBEEF0002, 32'h0,        5'd10, C_WRF|C_MTLO|C_MFLO,       1, 1, 5'd10, 32'hCAFE0001, 32'h12345678, 32'hCAFE0001);
    step(0, 0, 0, 0, 32'h0,        32'h0,        5'd0,  11'h0,                     0, 0, 5'd0,  32'h0,        32'h12345678, 32'hBEEF0002);
    // stall holds, flush beats stall
    step(0, 0, 0, 1, 32'h11,       32'h0,        5'd12, C_WRF,                     1, 1, 5'd12, 32'h11,       32'h12345678, 32'hBEEF0002);
    step(0, 1, 0, 1, 32'h99,       32'h0,        5'd1,  C_WRF|C_MTHI,              1, 1, 5'd12, 32'h11,       32'h12345678, 32'hBEEF0002);
    step(0, 1, 0, 0, 32'h98,       32'h0,        5'd2,  C_WRF|C_MTLO,              1, 1, 5'd12, 32'h11,       32'h12345678, 32'hBEEF0002);
    step(0, 1, 0, 1, 32'h97,       32'h0,        5'd3,  C_WRF,                     1, 1, 5'd12, 32'h11,       32'h12345678, 32'hBEEF0002);
    step(0, 1, 1, 1, 32'h96,       32'h0,        5'd4,  C_WRF,                     0, 0, 5'd0,  32'h0,        32'h12345678, 32'hBEEF0002);
    // reset while a stalled mthi sits in WB
    step(0, 0, 0, 1, 32'hDEAD0000, 32'h0,        5'd0,  C_MTHI,                    1, 0, 5'd0,  32'hDEAD0000, 32'h12345678, 32'hBEEF0002);
    step(0, 1, 0, 1, 32'h1,        32'h0,        5'd1,  C_WRF,                     1, 0, 5'd0,  32'hDEAD0000, 32'hDEAD0000, 32'hBEEF0002);
    step(1, 1, 0, 1, 32'h2,        32'h0,        5'd2,  C_WRF|C_MTHI,              0, 0, 5'd0,  32'h0,        32'h0,        32'h0);
    step(0, 1, 0, 1, 32'h3,        32'h0,        5'd3,  C_WRF|C_MTLO,              0, 0, 5'd0,  32'h0,        32'h0,        32'h0);

    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
